freqcmp_multi: RTL and testbench

Multi-channel, single-clock frequency comparator and successor to the two-clock helper-PLL frequency differencer. It counts synchronized edge pulses from NCH channels over a programmable gate window of reference-clock cycles. For each channel it produces a signed count error against a per-channel expected count, an exponentially averaged error, overflow flags and a lock indication. It sits in the clkref domain after per-channel edge synchronizers and feeds the helper-PLL loop filter and status registers.

---
 rtl/freqcmp_multi.sv | 178 +++++++++++++++++
 tb/tb_freqcmp_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/freqcmp_multi.sv
`default_nettype none
// ============================================================================
// Module   : freqcmp_multi
// Brief    : Gated multi-channel edge counter with signed error, averaged error,
//            saturation flags and lock detection, single reference clock.
// Revision : 1.0
// ============================================================================
module freqcmp_multi #(
    parameter int DWIDTH = 32,
    parameter int NCH    = 4,
    parameter int LOCKW  = 8
) (
    input  logic                    clkref,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          edges,
    input  logic [DWIDTH-1:0]       refcntsamp,
    input  logic [NCH*DWIDTH-1:0]   expcnt,
    input  logic [2:0]              avgshift,
    input  logic [DWIDTH-1:0]       locktol,
    input  logic [LOCKW-1:0]        lockcnt,
    output logic [NCH*DWIDTH-1:0]   freqdiff,
    output logic [NCH*DWIDTH-1:0]   freqavg,
    output logic                    stb_freqdiff,
    output logic [NCH-1:0]          locked,
    output logic [NCH-1:0]          ovf,
    output logic [DWIDTH-1:0]       wincnt
);

    localparam logic [DWIDTH-1:0] C_MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] C_MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                     r_state;
    logic [DWIDTH-1:0]          r_remaining;
    logic                       r_first;
    logic [NCH-1:0][DWIDTH-1:0] r_cnt;
    logic [NCH-1:0][DWIDTH-1:0] w_cnt_next;

    logic [NCH-1:0][DWIDTH-1:0] r_snap;
    logic [NCH-1:0]             r_snap_ovf;
    logic                       r_snap_vld;
    logic                       r_snap_seed;

    logic [NCH-1:0][DWIDTH-1:0] r_diff;
    logic [NCH-1:0][DWIDTH-1:0] w_diff_new;
    logic [NCH-1:0]             r_diff_ovf;
    logic                       r_diff_vld;
    logic                       r_diff_seed;

    logic [NCH-1:0][DWIDTH-1:0] r_freqdiff;
    logic [NCH-1:0][DWIDTH-1:0] r_avg;
    logic [NCH-1:0][DWIDTH-1:0] w_avg_new;
    logic [NCH-1:0][LOCKW-1:0]  r_run;
    logic [NCH-1:0][LOCKW-1:0]  w_run_new;
    logic [NCH-1:0]             w_in_tol;
    logic [NCH-1:0]             w_lock_new;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic signed [DWIDTH:0] w_raw;
            logic signed [DWIDTH:0] w_dx;
            logic signed [DWIDTH:0] w_ax;
            logic signed [DWIDTH:0] w_step;
            logic        [DWIDTH:0] w_abs;

            assign w_cnt_next[gi] = (edges[gi] && !(&r_cnt[gi])) ? r_cnt[gi] + 1'b1 : r_cnt[gi];

            assign w_raw = $signed({1'b0, r_snap[gi]}) - $signed({1'b0, expcnt[gi*DWIDTH +: DWIDTH]});
            // Top two bits disagree when the DWIDTH+1 result does not fit signed DWIDTH.
            assign w_diff_new[gi] = r_snap_ovf[gi]                   ? C_MAX_POS :
                                    (w_raw[DWIDTH] != w_raw[DWIDTH-1]) ? (w_raw[DWIDTH] ? C_MIN_NEG : C_MAX_POS) :
                                    w_raw[DWIDTH-1:0];

            assign w_dx   = $signed({r_diff[gi][DWIDTH-1], r_diff[gi]});
            assign w_ax   = $signed({r_avg[gi][DWIDTH-1], r_avg[gi]});
            assign w_step = (w_dx - w_ax) >>> avgshift;
            // The updated average always lies between old average and diff, so it fits DWIDTH.
            assign w_avg_new[gi] = r_diff_seed ? r_diff[gi] : DWIDTH'(w_ax + w_step);

            assign w_abs          = w_dx[DWIDTH] ? -w_dx : w_dx;
            assign w_in_tol[gi]   = !r_diff_ovf[gi] && (w_abs <= {1'b0, locktol});
            assign w_run_new[gi]  = !w_in_tol[gi]    ? '0 :
                                    (&r_run[gi])     ? r_run[gi] : r_run[gi] + 1'b1;
            assign w_lock_new[gi] = w_in_tol[gi] && (w_run_new[gi] >= lockcnt);
        end
    endgenerate

    always_ff @(posedge clkref or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_snap      <= '0;
            r_snap_ovf  <= '0;
            r_snap_vld  <= 1'b0;
            r_snap_seed <= 1'b0;
        end else begin
            r_snap_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (refcntsamp != '0) begin
                        r_remaining <= refcntsamp - 1'b1;
                        r_cnt       <= '0;
                        r_first     <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_remaining == '0) begin
                        r_snap      <= w_cnt_next;
                        for (int i = 0; i < NCH; i++) begin
                            r_snap_ovf[i] <= &w_cnt_next[i];
                        end
                        r_snap_vld  <= 1'b1;
                        r_snap_seed <= r_first;
                        r_first     <= 1'b0;
                        r_cnt       <= '0;
                        if (refcntsamp != '0) begin
                            r_remaining <= refcntsamp - 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_remaining <= r_remaining - 1'b1;
                        r_cnt       <= w_cnt_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkref or negedge rst_n) begin
        if (!rst_n) begin
            r_diff      <= '0;
            r_diff_ovf  <= '0;
            r_diff_vld  <= 1'b0;
            r_diff_seed <= 1'b0;
        end else begin
            r_diff_vld <= r_snap_vld;
            if (r_snap_vld) begin
                r_diff      <= w_diff_new;
                r_diff_ovf  <= r_snap_ovf;
                r_diff_seed <= r_snap_seed;
            end
        end
    end

    always_ff @(posedge clkref or negedge rst_n) begin
        if (!rst_n) begin
            r_freqdiff   <= '0;
            r_avg        <= '0;
            r_run        <= '0;
            locked       <= '0;
            ovf          <= '0;
            wincnt       <= '0;
            stb_freqdiff <= 1'b0;
        end else begin
            stb_freqdiff <= r_diff_vld;
            if (r_diff_vld) begin
                r_freqdiff <= r_diff;
                r_avg      <= w_avg_new;
                r_run      <= w_run_new;
                locked     <= w_lock_new;
                ovf        <= r_diff_ovf;
                wincnt     <= wincnt + 1'b1;
            end
        end
    end

    assign freqdiff = r_freqdiff;
    assign freqavg  = r_avg;

endmodule
`default_nettype wire

// File: tb/tb_freqcmp_multi.sv
`default_nettype none
// Bench for freqcmp_multi: table-driven windows with hand-computed results,
// plus restart, saturation and asynchronous-reset sequences (DWIDTH=8, NCH=2).
module tb_freqcmp_multi;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     edges;
    logic [DW-1:0]     refcntsamp;
    logic [NC*DW-1:0]  expcnt;
    logic [2:0]        avgshift;
    logic [DW-1:0]     locktol;
    logic [LW-1:0]     lockcnt;
    logic [NC*DW-1:0]  freqdiff;
    logic [NC*DW-1:0]  freqavg;
    logic              stb;
    logic [NC-1:0]     locked;
    logic [NC-1:0]     ovf;
    logic [DW-1:0]     wincnt;

    freqcmp_multi #(.DWIDTH(DW), .NCH(NC), .LOCKW(LW)) u_dut (
        .clkref(clk), .rst_n(rst_n), .edges(edges), .refcntsamp(refcntsamp),
        .expcnt(expcnt), .avgshift(avgshift), .locktol(locktol), .lockcnt(lockcnt),
        .freqdiff(freqdiff), .freqavg(freqavg), .stb_freqdiff(stb),
        .locked(locked), .ovf(ovf), .wincnt(wincnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One record per window: stimulus, config, and the result expected at its strobe.
    typedef struct {
        int w; int n0; int n1; int p1;
        int e0; int e1; int sh; int tol; int lc;
        int d0; int d1; int a0; int a1; int lk; int ov;
        int last; int at;
    } vec_t;

    vec_t tbl_a [10];
    vec_t tbl_b [4];
    vec_t v_sat, v_rst, e;
    vec_t exp_q [$];

    int errors = 0;
    int checks = 0;
    int nstb   = 0;
    int wexp   = 0;
    int g      = 0;
    int base;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_freqdiff"}, int'(freqdiff), 0);
        check({tag, "_freqavg"},  int'(freqavg), 0);
        check({tag, "_stb"},      int'(stb), 0);
        check({tag, "_locked"},   int'(locked), 0);
        check({tag, "_ovf"},      int'(ovf), 0);
        check({tag, "_wincnt"},   int'(wincnt), 0);
    endtask

    task automatic apply_cfg(input vec_t v);
        expcnt   = {8'(v.e1), 8'(v.e0)};
        avgshift = 3'(v.sh);
        locktol  = 8'(v.tol);
        lockcnt  = 8'(v.lc);
    endtask

    task automatic start(input vec_t v);
        refcntsamp = 8'(v.w);
        apply_cfg(v);
        edges = '0;
        @(posedge clk); #1;
        g = 0;
    endtask

    // Drives one window of v.w cycles; config changes land after the previous result is consumed.
    task automatic window(input vec_t v);
        for (int j = 0; j < v.w; j++) begin
            edges[0] = (j < v.n0);
            edges[1] = (v.p1 != 0) ? ((g % v.p1) == 0) : (j < v.n1);
            if (j == 3) begin
                apply_cfg(v);
                if (v.last != 0) refcntsamp = '0;
            end
            @(posedge clk); #1;
            g++;
        end
        edges = '0;
        v.at = cyc + 2;
        exp_q.push_back(v);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check({tag, "_pending_stb"}, exp_q.size(), 0);
        base = nstb;
        repeat (40) @(negedge clk);
        check({tag, "_idle_quiet"}, nstb - base, 0);
    endtask

    initial begin
        rst_n = 1'b0; edges = '0; refcntsamp = '0;
        expcnt = '0; avgshift = '0; locktol = '0; lockcnt = '0;

        //          w  n0  n1 p1  e0  e1 sh tol lc   d0    d1   a0   a1 lk ov last at
        tbl_a[0] = '{20, 18, 10, 0, 10, 10, 2, 1, 3,    8,  0,    8,  0, 0, 0, 0, 0};
        tbl_a[1] = '{20, 10, 11, 0, 10, 10, 2, 1, 3,    0,  1,    6,  0, 0, 0, 0, 0};
        tbl_a[2] = '{20, 10, 10, 0, 10, 10, 2, 1, 3,    0,  0,    4,  0, 2, 0, 0, 0};
        tbl_a[3] = '{20, 10, 15, 0, 10, 10, 2, 1, 3,    0,  5,    3,  1, 1, 0, 0, 0};
        tbl_a[4] = '{20, 10, 10, 0, 10, 10, 2, 1, 3,    0,  0,    2,  0, 1, 0, 0, 0};
        tbl_a[5] = '{20, 10, 10, 0, 10, 10, 2, 1, 3,    0,  0,    1,  0, 1, 0, 0, 0};
        tbl_a[6] = '{20, 10, 10, 0, 10, 10, 2, 1, 3,    0,  0,    0,  0, 3, 0, 0, 0};
        tbl_a[7] = '{20,  0, 10, 0, 10, 10, 0, 1, 3,  -10,  0,  -10,  0, 2, 0, 0, 0};
        tbl_a[8] = '{20,  0, 10, 0,200, 10, 1, 1, 3, -128,  0,  -69,  0, 2, 0, 0, 0};
        tbl_a[9] = '{20, 13,  9, 0, 10, 10, 1, 1, 3,    3, -1,  -33, -1, 2, 0, 1, 0};

        tbl_b[0] = '{100, 100, 0, 2, 100, 50, 1, 0, 0,  0,   0,  0,   0, 3, 0, 0, 0};
        tbl_b[1] = '{100, 100, 0, 3, 100, 50, 1, 0, 0,  0, -17,  0,  -9, 1, 0, 0, 0};
        tbl_b[2] = '{100, 100, 0, 3, 100, 50, 1, 0, 0,  0, -17,  0, -13, 1, 0, 0, 0};
        tbl_b[3] = '{100, 100, 0, 3, 100, 50, 1, 0, 0,  0, -16,  0, -15, 1, 0, 1, 0};

        v_sat    = '{255, 255, 0, 0, 10, 0, 0, 0, 0,  127,  0,  127,  0, 2, 1, 1, 0};
        v_rst    = '{20,  12, 10, 0, 10, 10, 2, 1, 0,    2,  0,    2,  0, 2, 0, 1, 0};

        fork
            forever begin
                @(negedge clk);
                if (rst_n && stb) begin
                    nstb++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_stb", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        wexp++;
                        check("stb_cycle",  cyc, e.at);
                        check("freqdiff0", int'($signed(freqdiff[7:0])),  e.d0);
                        check("freqdiff1", int'($signed(freqdiff[15:8])), e.d1);
                        check("freqavg0",  int'($signed(freqavg[7:0])),   e.a0);
                        check("freqavg1",  int'($signed(freqavg[15:8])),  e.a1);
                        check("locked",    int'(locked), e.lk);
                        check("ovf",       int'(ovf), e.ov);
                        check("wincnt",    int'(wincnt), wexp % 256);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk); #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("idle_no_stb", nstb, 0);

        // Back-to-back 20-cycle windows: averaging, lock runs, negative saturation.
        start(tbl_a[0]);
        for (int i = 0; i < 10; i++) window(tbl_a[i]);
        drain("phase_a");

        // Restart from IDLE reseeds; ch1 every 2nd then every 3rd cycle.
        start(tbl_b[0]);
        for (int i = 0; i < 4; i++) window(tbl_b[i]);
        drain("phase_b");

        // Counter reaches all-ones.
        start(v_sat);
        window(v_sat);
        drain("phase_sat");

        // Asynchronous reset mid-window discards the partial window.
        refcntsamp = 8'd20;
        edges = 2'b11;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        wexp = 0;
        base = nstb;
        start(v_rst);
        window(v_rst);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("rst_pending_stb", exp_q.size(), 0);
        repeat (40) @(negedge clk);
        check("rst_single_stb", nstb - base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
